// File: rtl/irq_pkg.sv
// Shared types and default sizing for the interrupt controller.
package irq_pkg;

  localparam int unsigned NSrcDefault  = 4;
  localparam int unsigned DataWDefault = 4;

  // Controller FSM: waiting for work, or holding an interrupt for the CPU.
  typedef enum logic [0:0] {
    StIdle,
    StPresent
  } irqState_e;

endpackage

// File: rtl/irq_controller_if.sv
// Bundle of source, control and CPU-facing signals of the interrupt controller.
interface irq_controller_if
  import irq_pkg::*;
#(
  parameter int unsigned N_SRC  = NSrcDefault,
  parameter int unsigned DATA_W = DataWDefault,
  localparam int unsigned ID_W  = $clog2(N_SRC)
) ();

  logic [N_SRC-1:0]        src_pulse;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic                    mask_wr;
  logic [N_SRC-1:0]        mask_in;
  logic                    irq_ack;
  logic                    ovr_clr;
  logic                    irq;
  logic [ID_W-1:0]         irq_id;
  logic [DATA_W-1:0]       irq_data;
  logic [N_SRC-1:0]        pending;
  logic [N_SRC-1:0]        overrun;

  // Driver of sources, mask and acknowledge (CPU / system side).
  modport master (
    output src_pulse, src_data, mask_wr, mask_in, irq_ack, ovr_clr,
    input  irq, irq_id, irq_data, pending, overrun
  );

  // The controller itself.
  modport slave (
    input  src_pulse, src_data, mask_wr, mask_in, irq_ack, ovr_clr,
    output irq, irq_id, irq_data, pending, overrun
  );

endinterface

// File: rtl/irq_controller_prio_enc.sv
// Fixed-priority encoder: lowest set request bit wins.
module prio_enc #(
  parameter int unsigned N     = 4,
  localparam int unsigned IdW  = $clog2(N)
) (
  input  logic [N-1:0]   req,
  output logic           valid,
  output logic [IdW-1:0] idx
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IdW'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: per-source pending/payload capture, masking, overrun
// tracking and fixed-priority presentation of one interrupt at a time.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned N_SRC  = NSrcDefault,
  parameter int unsigned DATA_W = DataWDefault,
  localparam int unsigned ID_W  = $clog2(N_SRC)
) (
  input logic             clk,
  input logic             rst,
  irq_controller_if.slave bus
);

  logic [N_SRC-1:0]  pendingQ, pendingD;
  logic [N_SRC-1:0]  overrunQ, overrunD;
  logic [N_SRC-1:0]  maskQ;
  logic [DATA_W-1:0] latchQ [N_SRC];
  logic [DATA_W-1:0] latchD [N_SRC];

  irqState_e         stateQ, stateD;
  logic              selQ, selD;
  logic              irqQ, irqD;
  logic [ID_W-1:0]   idQ, idD;
  logic [DATA_W-1:0] dataQ, dataD;

  logic              ackFire;
  logic [N_SRC-1:0]  ackVec;
  logic [N_SRC-1:0]  candReq;
  logic              candValid;
  logic [ID_W-1:0]   candId;

  // Acknowledge only counts while an interrupt is actually presented.
  assign ackFire = (stateQ == StPresent) && bus.irq_ack;
  assign ackVec  = ackFire ? (N_SRC'(1) << idQ) : '0;
  assign candReq = pendingQ & ~maskQ;

  prio_enc #(
    .N (N_SRC)
  ) u_prio_enc (
    .req   (candReq),
    .valid (candValid),
    .idx   (candId)
  );

  // Per-source pending, overrun and payload next state; a new pulse beats a
  // same-cycle acknowledge of that source.
  always_comb begin
    for (int i = 0; i < int'(N_SRC); i++) begin
      pendingD[i] = bus.src_pulse[i] | (pendingQ[i] & ~ackVec[i]);
      overrunD[i] = (bus.src_pulse[i] & pendingQ[i] & ~ackVec[i]) |
                    (overrunQ[i] & ~bus.ovr_clr);
      latchD[i]   = latchQ[i];
      if (bus.src_pulse[i] && (!pendingQ[i] || ackVec[i])) begin
        latchD[i] = bus.src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Presentation FSM: select in IDLE, raise irq one edge later, hold until ack.
  always_comb begin
    stateD = stateQ;
    selD   = selQ;
    irqD   = irqQ;
    idD    = idQ;
    dataD  = dataQ;
    unique case (stateQ)
      StIdle: begin
        if (selQ) begin
          stateD = StPresent;
          irqD   = 1'b1;
          selD   = 1'b0;
        end else if (candValid) begin
          selD  = 1'b1;
          idD   = candId;
          dataD = latchQ[candId];
        end
      end
      StPresent: begin
        if (bus.irq_ack) begin
          stateD = StIdle;
          irqD   = 1'b0;
        end
      end
      default: begin
        stateD = StIdle;
        irqD   = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pendingQ <= '0;
      overrunQ <= '0;
      maskQ    <= '0;
      for (int i = 0; i < int'(N_SRC); i++) begin
        latchQ[i] <= '0;
      end
      stateQ <= StIdle;
      selQ   <= 1'b0;
      irqQ   <= 1'b0;
      idQ    <= '0;
      dataQ  <= '0;
    end else begin
      pendingQ <= pendingD;
      overrunQ <= overrunD;
      if (bus.mask_wr) begin
        maskQ <= bus.mask_in;
      end
      for (int i = 0; i < int'(N_SRC); i++) begin
        latchQ[i] <= latchD[i];
      end
      stateQ <= stateD;
      selQ   <= selD;
      irqQ   <= irqD;
      idQ    <= idD;
      dataQ  <= dataD;
    end
  end

  assign bus.irq      = irqQ;
  assign bus.irq_id   = idQ;
  assign bus.irq_data = dataQ;
  assign bus.pending  = pendingQ;
  assign bus.overrun  = overrunQ;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with a cycle-level behavioural model.
module tb_irq_controller;

  localparam int NS = 4;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  irq_controller_if #(.N_SRC(NS), .DATA_W(DW)) bus ();

  irq_controller #(
    .N_SRC  (NS),
    .DATA_W (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  // Model state: what the CPU should see and what each source holds.
  bit       mIrq;
  bit       mChosen;
  int       mId;
  int       mData;
  bit [3:0] mPend;
  bit [3:0] mOvr;
  bit [3:0] mMask;
  int       mLatch [NS];

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic compareAll();
    chk("irq", int'(bus.irq), int'(mIrq));
    chk("irq_id", int'(bus.irq_id), mId);
    chk("irq_data", int'(bus.irq_data), mData);
    chk("pending", int'(bus.pending), int'(mPend));
    chk("overrun", int'(bus.overrun), int'(mOvr));
  endtask

  // Advance the model by one edge from the current inputs, clock the DUT, compare.
  task automatic tick();
    bit ack;
    int sel;
    int ackId;
    if (rst) begin
      mIrq = 0; mChosen = 0; mId = 0; mData = 0;
      mPend = '0; mOvr = '0; mMask = '0;
      for (int i = 0; i < NS; i++) mLatch[i] = 0;
    end else begin
      ack   = mIrq && bus.irq_ack;
      ackId = mId;
      // Presentation decisions use the state visible before this edge.
      if (mIrq) begin
        if (ack) mIrq = 0;
      end else if (mChosen) begin
        mIrq = 1;
        mChosen = 0;
      end else begin
        sel = -1;
        for (int i = 0; i < NS; i++) begin
          if (sel < 0 && mPend[i] && !mMask[i]) sel = i;
        end
        if (sel >= 0) begin
          mChosen = 1;
          mId = sel;
          mData = mLatch[sel];
        end
      end
      if (bus.ovr_clr) mOvr = '0;
      for (int i = 0; i < NS; i++) begin
        if (bus.src_pulse[i]) begin
          if (mPend[i] && !(ack && ackId == i)) mOvr[i] = 1;
          else mLatch[i] = int'(bus.src_data[i*DW +: DW]);
          mPend[i] = 1;
        end else if (ack && ackId == i) begin
          mPend[i] = 0;
        end
      end
      if (bus.mask_wr) mMask = bus.mask_in;
    end
    @(posedge clk);
    #1;
    compareAll();
  endtask

  task automatic idleInputs();
    bus.src_pulse = '0;
    bus.src_data  = '0;
    bus.mask_wr   = 1'b0;
    bus.mask_in   = '0;
    bus.irq_ack   = 1'b0;
    bus.ovr_clr   = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] which, input logic [15:0] data);
    bus.src_pulse = which;
    bus.src_data  = data;
    tick();
    bus.src_pulse = '0;
    bus.src_data  = '0;
  endtask

  task automatic ack();
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
  endtask

  initial begin
    idleInputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset irq", int'(bus.irq), 0);
    chk("reset pending", int'(bus.pending), 0);

    // Single pulse, latency t+2.
    pulse(4'b0010, 16'h0070);
    tick();
    chk("single irq at t+1", int'(bus.irq), 0);
    tick();
    chk("single irq at t+2", int'(bus.irq), 1);
    chk("single id", int'(bus.irq_id), 1);
    chk("single data", int'(bus.irq_data), 7);
    ack();
    chk("single irq after ack", int'(bus.irq), 0);
    chk("single pending after ack", int'(bus.pending), 0);

    // Simultaneous pulses: lower index first.
    pulse(4'b1010, 16'hC0A0);
    tick();
    tick();
    chk("dual first id", int'(bus.irq_id), 1);
    chk("dual first data", int'(bus.irq_data), 'hA);
    ack();
    chk("dual pending mid", int'(bus.pending), 'b1000);
    tick();
    chk("dual gap irq", int'(bus.irq), 0);
    tick();
    chk("dual second irq", int'(bus.irq), 1);
    chk("dual second id", int'(bus.irq_id), 3);
    chk("dual second data", int'(bus.irq_data), 'hC);
    ack();

    // Overrun keeps the older payload; ovr_clr vs. simultaneous event.
    pulse(4'b0001, 16'h0003);
    pulse(4'b0001, 16'h0009);
    chk("ovr set", int'(bus.overrun), 'b0001);
    tick();
    chk("ovr irq", int'(bus.irq), 1);
    chk("ovr data", int'(bus.irq_data), 3);
    bus.ovr_clr = 1'b1;
    tick();
    chk("ovr cleared", int'(bus.overrun), 0);
    pulse(4'b0001, 16'h0005);
    bus.ovr_clr = 1'b0;
    chk("ovr event beats clear", int'(bus.overrun), 'b0001);
    chk("ovr stable data", int'(bus.irq_data), 3);
    ack();
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;

    // Mask blocks selection but not pending; ack in IDLE is ignored.
    bus.mask_wr = 1'b1;
    bus.mask_in = 4'b0001;
    tick();
    bus.mask_wr = 1'b0;
    pulse(4'b0001, 16'h0005);
    tick();
    tick();
    chk("mask pending", int'(bus.pending), 'b0001);
    chk("mask irq low", int'(bus.irq), 0);
    ack();
    chk("idle ack ignored", int'(bus.pending), 'b0001);
    bus.mask_wr = 1'b1;
    bus.mask_in = 4'b0000;
    tick();
    bus.mask_wr = 1'b0;
    tick();
    chk("unmask +1 irq", int'(bus.irq), 0);
    tick();
    chk("unmask +2 irq", int'(bus.irq), 1);
    chk("unmask id", int'(bus.irq_id), 0);
    chk("unmask data", int'(bus.irq_data), 5);
    ack();

    // Ack with same-source pulse: set wins, new payload re-presented.
    pulse(4'b0100, 16'h0400);
    tick();
    tick();
    chk("reack first data", int'(bus.irq_data), 4);
    bus.irq_ack = 1'b1;
    pulse(4'b0100, 16'h0B00);
    bus.irq_ack = 1'b0;
    chk("reack pending", int'(bus.pending), 'b0100);
    chk("reack no overrun", int'(bus.overrun), 0);
    tick();
    tick();
    chk("reack irq", int'(bus.irq), 1);
    chk("reack id", int'(bus.irq_id), 2);
    chk("reack data", int'(bus.irq_data), 'hB);
    ack();

    // Reset while presenting, then normal operation.
    pulse(4'b1000, 16'h6000);
    tick();
    tick();
    chk("pre-reset irq", int'(bus.irq), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst irq", int'(bus.irq), 0);
    chk("rst id", int'(bus.irq_id), 0);
    chk("rst data", int'(bus.irq_data), 0);
    chk("rst pending", int'(bus.pending), 0);
    pulse(4'b0010, 16'h0020);
    tick();
    tick();
    chk("post-rst irq", int'(bus.irq), 1);
    chk("post-rst id", int'(bus.irq_id), 1);
    chk("post-rst data", int'(bus.irq_data), 2);
    ack();
    tick();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
